// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: prescaled multi-digit BCD up/down counter with load.
// Define BCD_TICK_SEG_DECODE_EN to add the seg_o seven-segment output.
module bcd_tick_counter #(
  parameter int CLK_DIV = 50_000_000,
  parameter int DIGITS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                tick_o,
`ifdef BCD_TICK_SEG_DECODE_EN
  output logic [7*DIGITS-1:0] seg_o,
`endif
  output logic                carry_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

  logic [DW-1:0]       r_div;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_tick;
  logic                r_carry;

  logic                w_step;
  logic [4*DIGITS-1:0] w_next;
  logic                w_wrap;
  logic [4*DIGITS-1:0] w_ld;

  assign w_step = en && (r_div == DMAX);

  // Next count: ripple a +1/-1 through the digits; a chain that
  // runs off the top digit is a wrap.
  always_comb begin : nxt
    logic       c;
    logic [3:0] d;
    w_next = r_bcd;
    c      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = r_bcd[4*i +: 4];
      if (c) begin
        if (up_dn) begin
          if (d >= 4'd9) begin
            w_next[4*i +: 4] = 4'd0;
          end else begin
            w_next[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            w_next[4*i +: 4] = 4'd9;
          end else begin
            w_next[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    w_wrap = c;
  end

  // Load value with every non-BCD digit clamped to 9.
  always_comb begin
    w_ld = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        w_ld[4*i +: 4] = 4'd9;
      end
    end
  end

  // Prescaler, count and pulse registers; load beats a coincident step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_bcd   <= '0;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else if (load) begin
      r_div   <= '0;
      r_bcd   <= w_ld;
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_tick  <= 1'b0;
      r_carry <= 1'b0;
      if (w_step) begin
        r_div   <= '0;
        r_bcd   <= w_next;
        r_tick  <= 1'b1;
        r_carry <= w_wrap;
      end else if (en) begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign bcd_o   = r_bcd;
  assign tick_o  = r_tick;
  assign carry_o = r_carry;

`ifdef BCD_TICK_SEG_DECODE_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Active-low segment patterns decoded straight from the count.
  always_comb begin
    seg_o = '0;
    for (int i = 0; i < DIGITS; i++) begin
      seg_o[7*i +: 7] = seg7(r_bcd[4*i +: 4]);
    end
  end
`endif

endmodule

// File: doc/bcd_tick_counter.md
Name: bcd_tick_counter

Overview:
Parametrised multi-digit BCD counter driven by an internal clock prescaler. It generates a one-cycle tick every CLK_DIV enabled clocks and steps the count once per tick. The count can go up or down, can be loaded, and wraps at 10^DIGITS with a carry/borrow pulse. It is the general timing/count source for display and timer logic in the digital-circuit experiments.

Parameters:
CLK_DIV, 50_000_000, enabled clk cycles per count step; legal range >=1, where 1 means a step every enabled cycle.
DIGITS, 2, number of BCD digits; legal range 1..8.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-high reset.
en  input  1  run/pause; 1 = prescaler advances, 0 = prescaler and count frozen.
up_dn  input  1  direction; 1 = count up, 0 = count down.
load  input  1  synchronous load strobe.
load_val  input  4*DIGITS  BCD load value; digit 0 is in bits [3:0].
bcd_o  output  4*DIGITS  current count in BCD; digit 0 is in bits [3:0].
tick_o  output  1  one-cycle pulse on every count step.
carry_o  output  1  one-cycle pulse when the count wraps in either direction.

Behaviour:
- Reset (async, rst=1): div_cnt=0, bcd_o=0, tick_o=0, carry_o=0. Outputs clear immediately, without waiting for a clk edge, and hold while rst=1.
- Prescaler:
  - div_cnt is $clog2(CLK_DIV)-bit wide, minimum 1 bit.
  - On a clk edge with en=1: if div_cnt==CLK_DIV-1, then div_cnt<=0 and step=1; otherwise div_cnt<=div_cnt+1.
  - en=0: div_cnt holds; it is not cleared.
- Step, on the same edge as step=1:
  - bcd_o updates and tick_o<=1 for exactly one cycle.
  - Tick period is exactly CLK_DIV cycles while en is held at 1.
  - First tick after reset release with en=1 occurs on the CLK_DIV-th rising edge.
- Up (up_dn=1):
  - digit0+1; any digit reaching 10 becomes 0 and carries into the next digit.
  - All digits 9 -> all 0, and carry_o<=1 on the same edge as tick_o.
- Down (up_dn=0):
  - digit0-1; any digit going below 0 becomes 9 and borrows from the next digit.
  - All digits 0 -> all 9, and carry_o<=1.
- up_dn is sampled only on step edges; a change takes effect from the next step.
- tick_o and carry_o are registered, and are 0 in every cycle except the step edge.
- Load (load=1 on a clk edge):
  - bcd_o<=load_val, with each digit >9 clamped to 9. div_cnt<=0; tick_o<=0; carry_o<=0.
  - Load has priority over a coincident step; that step is discarded.
  - Load works regardless of en.
- Priority: rst > load > step > hold.
- Only valid BCD (0..9 per digit) ever appears on bcd_o.

Optional Feature:
Macro: BCD_TICK_SEG_DECODE_EN
- Defined: adds output seg_o, width 7*DIGITS, carrying active-low seven-segment patterns.
  - Each digit is 7 bits, {g,f,e,d,c,b,a}; digit 0 is in [6:0].
  - seg_o is decoded combinationally from bcd_o; e.g. digit 0 -> 7'b1000000, digit 8 -> 7'b0000000.
  - Reset value follows bcd_o=0, i.e. all digits show "0".
- Undefined: seg_o port and decoder are absent; all other behaviour is identical.

Test Plan:
All scenarios use CLK_DIV=4, DIGITS=2.
1. Release rst, hold en=1, up_dn=1 -> bcd_o 0x01 at 4th edge, 0x02 at 8th edge; tick_o is 1 cycle wide with period 4; carry_o stays 0.
2. Load 0x98, up, en=1 -> 0x99 after 4 cycles, 0x00 after 8 cycles with carry_o=1 coincident with tick_o; 0x01 after 12 cycles with carry_o=0.
3. Load 0x00, up_dn=0 -> next step gives 0x99 with carry_o=1, then 0x98; also load 0x10, down -> next step gives 0x09 (borrow across digits), carry_o=0.
4. Drop en to 0 when div_cnt=2, hold 10 cycles -> bcd_o and tick_o frozen (tick_o=0); after en returns to 1, the step occurs on the 2nd enabled edge.
5. Load load_val=0xAF coincident with a step -> bcd_o=0x99, no tick/carry that cycle; next tick occurs exactly 4 cycles later.
6. Assert rst asynchronously mid-period with bcd_o=0x57 -> bcd_o=0x00, tick_o=0, carry_o=0 before the next clk edge; with BCD_TICK_SEG_DECODE_EN, seg_o=14'b1000000_1000000.
